// File: rtl/timer_apb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_apb_arbiter: round-robin two-requester APB master for the timer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module timer_apb_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_strb,
  output logic                m0_rsp_valid,
  output logic [DATA_W-1:0]   m0_rsp_rdata,
  output logic                m0_rsp_err,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_strb,
  output logic                m1_rsp_valid,
  output logic [DATA_W-1:0]   m1_rsp_rdata,
  output logic                m1_rsp_err,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic                tim_pready,
  input  logic                tim_pslverr,
  input  logic [DATA_W-1:0]   tim_prdata
);

  localparam int c_STRB_W    = DATA_W / 8;
  localparam int c_CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int c_TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(c_TO_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_last_grant;
  logic                 r_gnt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [ADDR_W-1:0]    r_paddr;
  logic [DATA_W-1:0]    r_pwdata;
  logic [c_STRB_W-1:0]  r_pstrb;
  logic                 r_m0_rsp_valid;
  logic [DATA_W-1:0]    r_m0_rsp_rdata;
  logic                 r_m0_rsp_err;
  logic                 r_m1_rsp_valid;
  logic [DATA_W-1:0]    r_m1_rsp_rdata;
  logic                 r_m1_rsp_err;

  logic                 w_idle;
  logic                 w_pick0;
  logic                 w_pick1;
  logic                 w_accept;
  logic                 w_acc_id;
  logic                 w_acc_write;
  logic [ADDR_W-1:0]    w_acc_addr;
  logic [DATA_W-1:0]    w_acc_wdata;
  logic [c_STRB_W-1:0]  w_acc_strb;
  logic                 w_misalign;
  logic                 w_timeout;
  logic                 w_rsp_fire;
  logic                 w_rsp_id;
  logic [DATA_W-1:0]    w_rsp_rdata;
  logic                 w_rsp_err;

  // On contention the requester that was not served last wins.
  assign w_pick0  = m0_valid & (~m1_valid | r_last_grant);
  assign w_pick1  = m1_valid & (~m0_valid | ~r_last_grant);
  assign w_idle   = (r_state == S_IDLE) & ~sys_rst;
  assign m0_ready = w_idle & w_pick0;
  assign m1_ready = w_idle & w_pick1;
  assign w_accept = m0_ready | m1_ready;
  assign w_acc_id = m1_ready;

  assign w_acc_write = w_acc_id ? m1_write : m0_write;
  assign w_acc_addr  = w_acc_id ? m1_addr  : m0_addr;
  assign w_acc_wdata = w_acc_id ? m1_wdata : m0_wdata;
  assign w_acc_strb  = w_acc_id ? m1_strb  : m0_strb;
  assign w_misalign  = (w_acc_addr[1:0] != 2'b00);
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  always_comb begin
    w_rsp_fire  = 1'b0;
    w_rsp_id    = r_gnt;
    w_rsp_rdata = '0;
    w_rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_misalign) begin
          w_rsp_fire = 1'b1;
          w_rsp_id   = w_acc_id;
          w_rsp_err  = 1'b1;
        end
      end
      S_ACCESS: begin
        if (tim_pready) begin
          w_rsp_fire  = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : tim_prdata;
          w_rsp_err   = tim_pslverr;
        end else if (w_timeout) begin
          w_rsp_fire = 1'b1;
          w_rsp_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_gnt          <= 1'b0;
      r_cnt          <= '0;
      r_psel         <= 1'b0;
      r_penable      <= 1'b0;
      r_pwrite       <= 1'b0;
      r_paddr        <= '0;
      r_pwdata       <= '0;
      r_pstrb        <= '0;
      r_m0_rsp_valid <= 1'b0;
      r_m0_rsp_rdata <= '0;
      r_m0_rsp_err   <= 1'b0;
      r_m1_rsp_valid <= 1'b0;
      r_m1_rsp_rdata <= '0;
      r_m1_rsp_err   <= 1'b0;
    end else begin
      r_m0_rsp_valid <= 1'b0;
      r_m1_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt        <= w_acc_id;
            r_last_grant <= w_acc_id;
            r_pwrite     <= w_acc_write;
            r_paddr      <= w_acc_addr;
            r_pwdata     <= w_acc_wdata;
            r_pstrb      <= w_acc_write ? w_acc_strb : '0;
            if (w_misalign) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_SETUP;
              r_psel  <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_rsp_fire) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Response data is only rewritten for the requester being answered.
      if (w_rsp_fire) begin
        if (w_rsp_id) begin
          r_m1_rsp_valid <= 1'b1;
          r_m1_rsp_rdata <= w_rsp_rdata;
          r_m1_rsp_err   <= w_rsp_err;
        end else begin
          r_m0_rsp_valid <= 1'b1;
          r_m0_rsp_rdata <= w_rsp_rdata;
          r_m0_rsp_err   <= w_rsp_err;
        end
      end
    end
  end

  assign tim_psel     = r_psel;
  assign tim_penable  = r_penable;
  assign tim_pwrite   = r_pwrite;
  assign tim_paddr    = r_paddr;
  assign tim_pwdata   = r_pwdata;
  assign tim_pstrb    = r_pstrb;
  assign m0_rsp_valid = r_m0_rsp_valid;
  assign m0_rsp_rdata = r_m0_rsp_rdata;
  assign m0_rsp_err   = r_m0_rsp_err;
  assign m1_rsp_valid = r_m1_rsp_valid;
  assign m1_rsp_rdata = r_m1_rsp_rdata;
  assign m1_rsp_err   = r_m1_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timer_apb_arbiter: randomized bench with transaction-level model.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_timer_apb_arbiter;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              m0_valid, m0_ready, m0_write, m0_rsp_valid, m0_rsp_err;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rsp_rdata;
  logic [STRB_W-1:0] m0_strb;
  logic              m1_valid, m1_ready, m1_write, m1_rsp_valid, m1_rsp_err;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rsp_rdata;
  logic [STRB_W-1:0] m1_strb;
  logic              tim_psel, tim_penable, tim_pwrite, tim_pready, tim_pslverr;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata, tim_prdata;
  logic [STRB_W-1:0] tim_pstrb;

  timer_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_strb(m0_strb), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_strb(m1_strb), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_pready(tim_pready), .tim_pslverr(tim_pslverr), .tim_prdata(tim_prdata)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          last_served;
  logic [31:0] hold_rd [2];
  logic        hold_err[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".psel"},    64'(tim_psel),     64'd0);
    check({tag, ".penable"}, 64'(tim_penable),  64'd0);
    check({tag, ".pwrite"},  64'(tim_pwrite),   64'd0);
    check({tag, ".paddr"},   64'(tim_paddr),    64'd0);
    check({tag, ".pwdata"},  64'(tim_pwdata),   64'd0);
    check({tag, ".pstrb"},   64'(tim_pstrb),    64'd0);
    check({tag, ".rv0"},     64'(m0_rsp_valid), 64'd0);
    check({tag, ".rv1"},     64'(m1_rsp_valid), 64'd0);
    check({tag, ".rd0"},     64'(m0_rsp_rdata), 64'd0);
    check({tag, ".rd1"},     64'(m1_rsp_rdata), 64'd0);
    check({tag, ".err0"},    64'(m0_rsp_err),   64'd0);
    check({tag, ".err1"},    64'(m1_rsp_err),   64'd0);
  endtask

  task automatic model_reset();
    last_served = 1;
    hold_rd[0] = '0; hold_rd[1] = '0;
    hold_err[0] = 1'b0; hold_err[1] = 1'b0;
  endtask

  // One command end to end. The winner carries the given fields, the loser
  // random ones and stays valid for the whole transaction.
  task automatic txn(input bit v0, input bit v1, input bit wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                     input int waits, input bit slverr, input logic [DATA_W-1:0] prdata);
    int          win, alen, rlen;
    bit          mis, to;
    logic [31:0] exp_rd;
    bit          exp_err;
    win  = (v0 && v1) ? ((last_served == 1) ? 0 : 1) : (v0 ? 0 : 1);
    mis  = (addr % 4) != 0;
    to   = (TIMEOUT != 0) && (waits >= TIMEOUT);
    alen = to ? TIMEOUT : waits + 1;
    rlen = mis ? 1 : 2 + alen;
    if (mis || to) begin
      exp_rd = 32'h0; exp_err = 1'b1;
    end else begin
      exp_rd = wr ? 32'h0 : prdata; exp_err = slverr;
    end

    @(negedge sys_clk);
    m0_write = 1'($urandom); m0_addr = ADDR_W'($urandom); m0_wdata = $urandom; m0_strb = STRB_W'($urandom);
    m1_write = 1'($urandom); m1_addr = ADDR_W'($urandom); m1_wdata = $urandom; m1_strb = STRB_W'($urandom);
    if (win == 0) begin
      m0_write = wr; m0_addr = addr; m0_wdata = wdata; m0_strb = strb;
    end else begin
      m1_write = wr; m1_addr = addr; m1_wdata = wdata; m1_strb = strb;
    end
    m0_valid = v0;
    m1_valid = v1;
    #1;
    check("grant.ready0", 64'(m0_ready), 64'(win == 0));
    check("grant.ready1", 64'(m1_ready), 64'(win == 1));
    last_served = win;

    for (int k = 1; k <= rlen; k++) begin
      @(negedge sys_clk);
      check("psel",    64'(tim_psel),    64'(!mis && k <= 1 + alen));
      check("penable", 64'(tim_penable), 64'(!mis && k >= 2 && k <= 1 + alen));
      if (!mis && k <= 1 + alen) begin
        check("paddr",  64'(tim_paddr),  64'(addr));
        check("pwrite", 64'(tim_pwrite), 64'(wr));
        check("pwdata", 64'(tim_pwdata), 64'(wdata));
        check("pstrb",  64'(tim_pstrb),  wr ? 64'(strb) : 64'd0);
      end
      if (k == rlen) begin
        hold_rd[win] = exp_rd; hold_err[win] = exp_err;
      end
      check("rsp_valid0", 64'(m0_rsp_valid), 64'(k == rlen && win == 0));
      check("rsp_valid1", 64'(m1_rsp_valid), 64'(k == rlen && win == 1));
      check("rsp_rdata0", 64'(m0_rsp_rdata), 64'(hold_rd[0]));
      check("rsp_rdata1", 64'(m1_rsp_rdata), 64'(hold_rd[1]));
      check("rsp_err0",   64'(m0_rsp_err),   64'(hold_err[0]));
      check("rsp_err1",   64'(m1_rsp_err),   64'(hold_err[1]));
      check("busy.ready0", 64'(m0_ready), 64'd0);
      check("busy.ready1", 64'(m1_ready), 64'd0);
      if (win == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
      if (!mis && !to && k == 2 + waits) begin
        tim_pready = 1'b1; tim_prdata = prdata; tim_pslverr = slverr;
      end else begin
        tim_pready = 1'b0; tim_prdata = $urandom; tim_pslverr = 1'($urandom);
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int                v, w;
    sys_rst = 1'b1;
    m0_valid = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
    m1_valid = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
    tim_pready = 0; tim_pslverr = 0; tim_prdata = '0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    check("reset.ready0", 64'(m0_ready), 64'd0);
    check("reset.ready1", 64'(m1_ready), 64'd0);
    sys_rst = 1'b0;

    txn(1, 0, 1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
    txn(0, 1, 0, 12'h008, 32'h0, 4'hA, 3, 0, 32'h12345678);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 1'($urandom), 12'(i * 4 + 16), $urandom, 4'($urandom), $urandom_range(0, 2), 0, $urandom);
    txn(1, 0, 0, 12'h006, 32'h0, 4'h0, 0, 0, 32'hFFFF0000);
    txn(1, 0, 0, 12'h020, 32'h0, 4'h0, 1, 1, 32'hCAFEF00D);
    txn(0, 1, 1, 12'h030, 32'h55AA55AA, 4'h3, 100, 0, 32'h0);
    txn(0, 1, 0, 12'h034, 32'h0, 4'h0, 15, 0, 32'hA5A5A5A5);
    txn(1, 1, 0, 12'h038, 32'h0, 4'h0, 0, 0, 32'h0BADCAFE);

    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(1, 3);
      a = ADDR_W'($urandom);
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 4);
      txn(v[0], v[1], 1'($urandom), a, $urandom, 4'($urandom), w, 1'($urandom), $urandom);
    end

    // Reset while the transfer sits in ACCESS.
    @(negedge sys_clk);
    m1_valid = 1; m1_write = 0; m1_addr = 12'h010; m0_valid = 0;
    #1;
    check("rstmid.ready1", 64'(m1_ready), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge sys_clk);
      m1_valid = 0; tim_pready = 0;
      if (k == 3) sys_rst = 1'b1;
    end
    @(negedge sys_clk);
    check_all_zero("rstmid");
    sys_rst = 1'b0;
    model_reset();
    txn(1, 1, 1, 12'h00C, 32'h01020304, 4'h5, 0, 0, 32'h0);
    txn(1, 1, 0, 12'h01C, 32'h0, 4'h0, 2, 0, 32'h77778888);

    repeat (2) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_apb_arbiter.md
Name: timer_apb_arbiter

Overview:
- Two-requester APB master front-end that shares the timer's single APB slave port (tim_* bus) between requester 0 (host CPU bridge) and requester 1 (debug/config sequencer).
- Accepts one command at a time using a round-robin grant, then runs a compliant SETUP/ACCESS sequence on the timer.
- Returns read data and error status to the granted requester.
- Aborts with an error on a misaligned address or when tim_pready times out.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width. Strobe width is DATA_W/8.
- TIMEOUT, 16, maximum number of ACCESS cycles waited for tim_pready. A value of 0 disables the timeout.

Ports:
- sys_clk  in  1  clock. This is the only clock in the block.
- sys_rst  in  1  synchronous, active-high reset.
- m0_valid, m1_valid  in  1  command request.
- m0_ready, m1_ready  out  1  command accepted this cycle (valid&ready).
- m0_write, m1_write  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_strb, m1_strb  in  DATA_W/8  byte strobes.
- m0_rsp_valid, m1_rsp_valid  out  1  one-cycle response pulse.
- m0_rsp_rdata, m1_rsp_rdata  out  DATA_W  read data. Valid with rsp_valid.
- m0_rsp_err, m1_rsp_err  out  1  error flag. Valid with rsp_valid.
- tim_psel, tim_penable, tim_pwrite  out  1  APB control.
- tim_paddr  out  ADDR_W  APB address.
- tim_pwdata  out  DATA_W  APB write data.
- tim_pstrb  out  DATA_W/8  APB strobes.
- tim_pready, tim_pslverr  in  1  APB completion and error.
- tim_prdata  in  DATA_W  APB read data.

Behaviour:
- Clocking and reset: one clock, sys_clk. sys_rst is synchronous and active-high.
- Reset values: every output is 0, state = IDLE, last_grant = 1 (so m0 wins first), timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - mX_ready is combinational and asserts only in IDLE, only for the requester the round-robin picks.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - On accept, latch write/addr/wdata/strb and the grant id; last_grant <= grant id.
  - addr[1:0] != 0: next state is RESP with err=1, rdata=0, and no APB transfer.
  - Otherwise next state is SETUP.
  - If valid drops before ready, there is no side effect.
- SETUP:
  - tim_psel=1, tim_penable=0.
  - paddr/pwrite/pwdata are driven from the latches.
  - tim_pstrb = latched strb for writes, 0 for reads.
  - Next state is always ACCESS.
- ACCESS:
  - tim_psel=1, tim_penable=1. All APB address/data/control held stable.
  - tim_pready=1: capture prdata (0 on writes) and pslverr, then go to RESP.
  - tim_pready=0: increment the timeout counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with pready still 0, go to RESP with err=1, rdata=0.
- Leaving ACCESS: psel and penable return to 0. The timeout counter clears on every SETUP entry.
- RESP:
  - The granted requester's rsp_valid=1 for exactly one cycle.
  - rsp_rdata/rsp_err are registered and hold their value until that requester's next response.
  - The other requester's rsp_valid stays 0.
  - Next state is IDLE. No command is accepted while in RESP.
- Latency:
  - Accept at cycle T, SETUP at T+1, ACCESS at T+2.
  - With zero-wait pready, rsp_valid at T+3 and the next accept at the earliest at T+4.
  - Each pready wait state adds 1 cycle.
  - A misaligned command responds at T+1.
- Outputs: all APB outputs and rsp signals are registered. Only mX_ready is combinational.
- Reset mid-transfer: state returns to IDLE on the next edge. psel/penable go to 0, no response is issued, and the in-flight command is dropped.
- tim_pslverr is sampled only in ACCESS with tim_pready=1. It is ignored otherwise.

Test Plan:
- Single write from m0: addr=0x004, wdata=0xDEADBEEF, strb=0xF, pready=1 at once.
  - Required: psel rises at T+1, penable at T+2; pwdata=0xDEADBEEF and pstrb=0xF held; m0_rsp_valid pulse at T+3 with err=0.
- Read from m1 with 3 wait states: prdata=0x12345678.
  - Required: pstrb=0; m1_rsp_rdata=0x12345678 at T+6; m0_rsp_valid stays 0.
- m0 and m1 valid continuously for 4 commands.
  - Required: grant order m0, m1, m0, m1; no overlap of psel between transfers; each response goes only to its own requester.
- Misaligned addr=0x006 from m0.
  - Required: psel never asserts; m0_rsp_valid at T+1 with err=1 and rdata=0. A read with pslverr=1 then returns err=1.
- Timeout with TIMEOUT=16 and pready held 0.
  - Required: ACCESS lasts 16 cycles; then psel=0, rsp_err=1, rdata=0; the next command proceeds normally.
- sys_rst asserted during ACCESS.
  - Required: on the next edge all outputs are 0 and there is no rsp_valid; after release, m0 wins a simultaneous request.
